// File: rtl/rcu_pll_ctrl.sv
// PLL reconfiguration sequencer: gates sys_clk, bypasses and resets the PLL, waits for a
// stable relock and ungates again, falling back to bypass on lock timeout.
module rcu_pll_ctrl #(
    parameter int SETTLE_CYC   = 8,
    parameter int RST_CYC      = 16,
    parameter int LOCK_STABLE  = 4,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cfg_valid_i,
    output logic       cfg_ready_o,
    input  logic [2:0] cfg_i,
    input  logic       pll_lock_i,
    output logic [2:0] pll_cfg_o,
    output logic       pll_bp_o,
    output logic       pll_rst_n_o,
    output logic       clk_gate_o,
    output logic [2:0] cur_cfg_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic       lol_o,
    input  logic       err_clr_i,
    output logic [2:0] state_o
);

    localparam int MAX_A   = (SETTLE_CYC > RST_CYC) ? SETTLE_CYC : RST_CYC;
    localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int CW      = $clog2(MAX_CYC);
    localparam int SW      = $clog2(LOCK_STABLE + 1);

    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STABLE_DONE  = SW'(LOCK_STABLE);

    typedef enum logic [2:0] {
        S_IDLE, S_GATE, S_BYPASS, S_PRST, S_RELOCK, S_UNBYP, S_UNGATE, S_FAIL
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [SW-1:0] stable, stable_n, stable_inc;
    logic [2:0]    pend_cfg, pend_n;
    logic          lock_s1, lock_sync;
    logic          xfer;
    logic          err_set, lol_set;
    logic [2:0]    pll_cfg_n, cur_n;
    logic          bp_n, prst_n_n, gate_n, done_n, err_n, lol_n;

    // Handshake: a request transfers on a clock edge where cfg_valid_i && cfg_ready_o;
    // cfg_ready_o is high only in IDLE, so a request made while busy waits with its
    // cfg_i held until the sequence finishes.
    assign xfer       = cfg_valid_i && cfg_ready_o;
    assign stable_inc = lock_sync ? stable + SW'(1) : '0;
    assign state_o    = state;

    always_comb begin
        state_n   = state;
        stable_n  = stable;
        pend_n    = pend_cfg;
        pll_cfg_n = pll_cfg_o;
        cur_n     = cur_cfg_o;
        bp_n      = pll_bp_o;
        prst_n_n  = pll_rst_n_o;
        gate_n    = clk_gate_o;
        done_n    = 1'b0;
        err_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (xfer) begin
                    state_n = S_GATE;
                    pend_n  = cfg_i;
                    gate_n  = 1'b1;
                end
            end
            S_GATE: begin
                if (cnt == SETTLE_LAST) begin
                    state_n   = S_BYPASS;
                    bp_n      = 1'b1;
                    pll_cfg_n = pend_cfg;
                    prst_n_n  = 1'b0;
                end
            end
            S_BYPASS: begin
                if (cnt == SETTLE_LAST) begin
                    state_n = (pend_cfg[2:1] == 2'b00) ? S_UNGATE : S_PRST;
                end
            end
            S_PRST: begin
                if (cnt == RST_LAST) begin
                    state_n  = S_RELOCK;
                    prst_n_n = 1'b1;
                    stable_n = '0;
                end
            end
            S_RELOCK: begin
                stable_n = stable_inc;
                // Accepted lock takes priority over a timeout in the same cycle.
                if (stable_inc == STABLE_DONE) begin
                    state_n = S_UNBYP;
                    bp_n    = 1'b0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_n   = S_FAIL;
                    bp_n      = 1'b1;
                    prst_n_n  = 1'b0;
                    pll_cfg_n = 3'b000;
                end
            end
            S_UNBYP: begin
                if (cnt == SETTLE_LAST) state_n = S_UNGATE;
            end
            S_UNGATE: begin
                state_n = S_IDLE;
                gate_n  = 1'b0;
                cur_n   = pend_cfg;
                done_n  = 1'b1;
            end
            S_FAIL: begin
                state_n = S_IDLE;
                gate_n  = 1'b0;
                cur_n   = 3'b000;
                err_set = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        cnt_n   = (state_n != state || state == S_IDLE) ? '0 : cnt + CW'(1);
        lol_set = (state == S_IDLE) && (cur_cfg_o[2:1] != 2'b00) && !lock_sync;
        err_n   = err_set || (err_o && !err_clr_i);
        lol_n   = lol_set || (lol_o && !err_clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            stable      <= '0;
            pend_cfg    <= 3'b000;
            lock_s1     <= 1'b0;
            lock_sync   <= 1'b0;
            pll_cfg_o   <= 3'b000;
            cur_cfg_o   <= 3'b000;
            pll_bp_o    <= 1'b1;
            pll_rst_n_o <= 1'b0;
            clk_gate_o  <= 1'b0;
            cfg_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            lol_o       <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            stable      <= stable_n;
            pend_cfg    <= pend_n;
            lock_s1     <= pll_lock_i;
            lock_sync   <= lock_s1;
            pll_cfg_o   <= pll_cfg_n;
            cur_cfg_o   <= cur_n;
            pll_bp_o    <= bp_n;
            pll_rst_n_o <= prst_n_n;
            clk_gate_o  <= gate_n;
            cfg_ready_o <= (state_n == S_IDLE);
            busy_o      <= (state_n != S_IDLE);
            done_o      <= done_n;
            err_o       <= err_n;
            lol_o       <= lol_n;
        end
    end

endmodule

// File: tb/tb_rcu_pll_ctrl.sv
// Bench for rcu_pll_ctrl: vector table, hand-written corner sequences and randomized
// lock patterns checked against a latency/outcome model of the sequencer.
module tb_rcu_pll_ctrl;

    localparam int SETTLE  = 8;
    localparam int RSTC    = 16;
    localparam int LSTABLE = 4;
    localparam int TIMEOUT = 4096;

    logic       clk_i, rst_n_i, cfg_valid_i, cfg_ready_o, pll_lock_i;
    logic [2:0] cfg_i, pll_cfg_o, cur_cfg_o, state_o;
    logic       pll_bp_o, pll_rst_n_o, clk_gate_o, busy_o, done_o, err_o, lol_o, err_clr_i;

    int n_checks = 0;
    int n_err    = 0;
    bit lock_pat[$];

    typedef struct {
        logic [2:0] code;
        int         dly;
        int         exp_lat;
        logic       exp_bp;
        logic       exp_rst_n;
        logic [2:0] exp_cur;
    } vec_t;

    vec_t tbl[6];

    rcu_pll_ctrl #(
        .SETTLE_CYC(SETTLE), .RST_CYC(RSTC), .LOCK_STABLE(LSTABLE), .LOCK_TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_i(cfg_i), .pll_lock_i(pll_lock_i), .pll_cfg_o(pll_cfg_o), .pll_bp_o(pll_bp_o),
        .pll_rst_n_o(pll_rst_n_o), .clk_gate_o(clk_gate_o), .cur_cfg_o(cur_cfg_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .lol_o(lol_o),
        .err_clr_i(err_clr_i), .state_o(state_o)
    );

    // clock / reset block
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, cfg_ready_o, 1'b1);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_done"}, done_o, 1'b0);
        chk({tag, "_err"}, err_o, 1'b0);
        chk({tag, "_lol"}, lol_o, 1'b0);
        chk({tag, "_gate"}, clk_gate_o, 1'b0);
        chk({tag, "_bp"}, pll_bp_o, 1'b1);
        chk({tag, "_pll_rst_n"}, pll_rst_n_o, 1'b0);
        chk({tag, "_pll_cfg"}, pll_cfg_o, 3'b000);
        chk({tag, "_cur_cfg"}, cur_cfg_o, 3'b000);
    endtask

    function automatic bit pat_at(input int i);
        if (i < lock_pat.size()) return lock_pat[i];
        return lock_pat[lock_pat.size()-1];
    endfunction

    task automatic set_delay_pat(input int dly);
        lock_pat.delete();
        for (int i = 0; i < dly; i++) lock_pat.push_back(1'b0);
        lock_pat.push_back(1'b1);
    endtask

    // Reference model: relock time is set by the first run of LSTABLE high lock samples
    // plus the two synchronizer stages; the rest of the sequence is fixed phase lengths.
    function automatic int relock_need();
        int run = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            run = pat_at(i) ? run + 1 : 0;
            if (run == LSTABLE) return i + 3;
        end
        return TIMEOUT + 1;
    endfunction

    function automatic int model_latency(input logic [2:0] code, output bit ok);
        int r;
        if (code < 3'd2) begin
            ok = 1'b1;
            return 2 * SETTLE + 1;
        end
        r = relock_need();
        if (r <= TIMEOUT) begin
            ok = 1'b1;
            return 3 * SETTLE + RSTC + r + 1;
        end
        ok = 1'b0;
        return 2 * SETTLE + RSTC + TIMEOUT + 1;
    endfunction

    // driver: one request, with a PLL model driving lock from lock_pat after reset release
    task automatic do_req(input logic [2:0] code, output int lat, output bit got_done,
                          output bit got_err);
        bit seen_rst, locked, fin, v;
        int since, run;
        logic prev_bp;
        logic [2:0] prev_cfg;
        seen_rst = 0; locked = 0; fin = 0; since = 0; run = 0;
        lat = 0; got_done = 0; got_err = 0;
        @(negedge clk_i);
        cfg_valid_i = 1'b1;
        cfg_i = code;
        prev_bp = pll_bp_o;
        prev_cfg = pll_cfg_o;
        for (int k = 1; k <= 6000 && !fin; k++) begin
            @(negedge clk_i);
            if (k == 1) cfg_valid_i = 1'b0;
            if (pll_bp_o !== prev_bp || pll_cfg_o !== prev_cfg)
                chk("gate_on_bp_cfg_change", clk_gate_o, 1'b1);
            if (prev_bp === 1'b1 && pll_bp_o === 1'b0)
                chk("bp_fall_after_lock", locked, 1'b1);
            prev_bp = pll_bp_o;
            prev_cfg = pll_cfg_o;
            if (done_o === 1'b1 || err_o === 1'b1) begin
                lat = k - 1;
                got_done = done_o;
                got_err = err_o;
                fin = 1;
            end
            if (pll_rst_n_o === 1'b0) begin
                seen_rst = 1; since = 0; run = 0; locked = 0;
                pll_lock_i = 1'b0;
            end else if (seen_rst) begin
                if (locked) pll_lock_i = 1'b1;
                else begin
                    v = pat_at(since);
                    pll_lock_i = v;
                    run = v ? run + 1 : 0;
                    if (run >= LSTABLE) locked = 1;
                    since++;
                end
            end
        end
        if (!fin) begin
            n_checks++;
            n_err++;
            $display("FAIL seq_bound: no done or err within 6000 cycles, code %0h", code);
        end
    endtask

    initial begin
        int lat, exp_lat, len;
        bit gd, ge, ok, got, got2, stall_ok, seen_low;
        logic [2:0] code;

        rst_n_i = 1'b0; cfg_valid_i = 1'b0; cfg_i = 3'b000; pll_lock_i = 1'b0; err_clr_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_reset("reset");
        rst_n_i = 1'b1;
        @(negedge clk_i);

        tbl[0] = '{3'b011, 10, 57, 1'b0, 1'b1, 3'b011};
        tbl[1] = '{3'b001,  0, 17, 1'b1, 1'b0, 3'b001};
        tbl[2] = '{3'b111,  0, 47, 1'b0, 1'b1, 3'b111};
        tbl[3] = '{3'b111,  0, 47, 1'b0, 1'b1, 3'b111};
        tbl[4] = '{3'b000,  0, 17, 1'b1, 1'b0, 3'b000};
        tbl[5] = '{3'b110, 25, 72, 1'b0, 1'b1, 3'b110};
        for (int i = 0; i < 6; i++) begin
            set_delay_pat(tbl[i].dly);
            do_req(tbl[i].code, lat, gd, ge);
            chk($sformatf("tbl%0d_done", i), gd, 1'b1);
            chk($sformatf("tbl%0d_latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("tbl%0d_bp", i), pll_bp_o, tbl[i].exp_bp);
            chk($sformatf("tbl%0d_pll_rst_n", i), pll_rst_n_o, tbl[i].exp_rst_n);
            chk($sformatf("tbl%0d_cur_cfg", i), cur_cfg_o, tbl[i].exp_cur);
            chk($sformatf("tbl%0d_pll_cfg", i), pll_cfg_o, tbl[i].code);
            chk($sformatf("tbl%0d_gate", i), clk_gate_o, 1'b0);
            chk($sformatf("tbl%0d_ready", i), cfg_ready_o, 1'b1);
            chk($sformatf("tbl%0d_busy", i), busy_o, 1'b0);
            chk($sformatf("tbl%0d_err", i), err_o, 1'b0);
        end

        // lock chatter: high 3, low 1, high 4 restarts the stable count
        lock_pat.delete();
        lock_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        do_req(3'b101, lat, gd, ge);
        chk("chatter_done", gd, 1'b1);
        chk("chatter_latency", lat, 51);
        chk("chatter_bp", pll_bp_o, 1'b0);

        // request held valid while busy stalls until the cycle after done_o
        cfg_i = 3'b001;
        @(negedge clk_i);
        cfg_valid_i = 1'b1;
        stall_ok = 1; got = 0; lat = 0;
        for (int k = 1; k <= 100 && !got; k++) begin
            @(negedge clk_i);
            if (done_o) begin got = 1; lat = k - 1; end
            else if (cfg_ready_o) stall_ok = 0;
        end
        chk("hold_done_seen", got, 1'b1);
        chk("hold_latency", lat, 17);
        chk("hold_stalled", stall_ok, 1'b1);
        chk("hold_ready_at_done", cfg_ready_o, 1'b1);
        @(negedge clk_i);
        chk("hold_second_busy", busy_o, 1'b1);
        chk("hold_second_ready_low", cfg_ready_o, 1'b0);
        cfg_valid_i = 1'b0;
        got2 = 0;
        for (int k = 1; k <= 100 && !got2; k++) begin
            @(negedge clk_i);
            if (done_o) got2 = 1;
        end
        chk("hold_second_done", got2, 1'b1);

        // loss of lock while idle at 8x, and clear-versus-set priority
        set_delay_pat(0);
        do_req(3'b111, lat, gd, ge);
        chk("lol_setup_latency", lat, 47);
        chk("lol_before_drop", lol_o, 1'b0);
        pll_lock_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("lol_sync_delay", lol_o, 1'b0);
        @(negedge clk_i);
        chk("lol_set", lol_o, 1'b1);
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        chk("lol_set_wins_clear", lol_o, 1'b1);
        pll_lock_i = 1'b1;
        repeat (3) @(negedge clk_i);
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        chk("lol_cleared", lol_o, 1'b0);

        // lock never arrives: timeout into the safe fallback
        lock_pat.delete();
        lock_pat.push_back(1'b0);
        do_req(3'b010, lat, gd, ge);
        chk("timeout_no_done", gd, 1'b0);
        chk("timeout_err", ge, 1'b1);
        chk("timeout_latency", lat, 4129);
        chk("timeout_cur_cfg", cur_cfg_o, 3'b000);
        chk("timeout_pll_cfg", pll_cfg_o, 3'b000);
        chk("timeout_bp", pll_bp_o, 1'b1);
        chk("timeout_pll_rst_n", pll_rst_n_o, 1'b0);
        chk("timeout_gate", clk_gate_o, 1'b0);
        chk("timeout_ready", cfg_ready_o, 1'b1);
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        chk("err_cleared", err_o, 1'b0);
        chk("lol_after_fail", lol_o, 1'b0);

        // asynchronous reset in the middle of RELOCK
        pll_lock_i = 1'b0;
        @(negedge clk_i);
        cfg_valid_i = 1'b1;
        cfg_i = 3'b011;
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
        got = 0; seen_low = 0;
        for (int k = 1; k <= 100 && !got; k++) begin
            @(negedge clk_i);
            if (!pll_rst_n_o) seen_low = 1;
            else if (seen_low) got = 1;
        end
        chk("arst_reached_relock", got, 1'b1);
        repeat (3) @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1 check_reset("arst");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        set_delay_pat(0);
        do_req(3'b011, lat, gd, ge);
        chk("arst_next_done", gd, 1'b1);
        chk("arst_next_latency", lat, 47);
        chk("arst_next_cur_cfg", cur_cfg_o, 3'b011);

        // randomized codes and lock patterns against the model
        for (int n = 0; n < 20; n++) begin
            code = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 20);
            lock_pat.delete();
            for (int i = 0; i < len - 1; i++) lock_pat.push_back(1'($urandom_range(0, 1)));
            lock_pat.push_back(1'b1);
            exp_lat = model_latency(code, ok);
            do_req(code, lat, gd, ge);
            chk($sformatf("rnd%0d_done", n), gd, ok);
            chk($sformatf("rnd%0d_latency", n), lat, exp_lat);
            chk($sformatf("rnd%0d_cur_cfg", n), cur_cfg_o, ok ? code : 3'b000);
            chk($sformatf("rnd%0d_bp", n), pll_bp_o, (ok && code >= 3'd2) ? 1'b0 : 1'b1);
        end
        chk("rnd_final_err", err_o, 1'b0);
        chk("rnd_final_lol", lol_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rcu_pll_ctrl.md
# rcu_pll_ctrl

PLL reconfiguration sequencer sitting beside the reset/clock unit, clocked from the buffered crystal reference. It accepts a 3-bit frequency code from the system register file through a valid/ready handshake, then safely walks the clock tree through gate, bypass, PLL reset, relock and ungate. It reports completion, lock timeout and loss-of-lock so that software can change the core frequency at runtime without glitching `sys_clk`.

## Interface
Parameters:
- `SETTLE_CYC`, default 8: duration of the gate and bypass settle phases, in `clk_i` cycles (≥2).
- `RST_CYC`, default 16: PLL reset pulse width, in `clk_i` cycles (≥1).
- `LOCK_STABLE`, default 4: number of consecutive synchronized lock-high cycles required to accept lock (≥1).
- `LOCK_TIMEOUT`, default 4096: maximum relock wait, in `clk_i` cycles (> `LOCK_STABLE` + 2).

Ports:
- `clk_i` in 1: crystal reference clock. This is the only clock.
- `rst_n_i` in 1: reset, asynchronous and active-low.
- `cfg_valid_i` in 1: new frequency code request.
- `cfg_ready_o` out 1: high only in IDLE.
- `cfg_i` in 3: requested code, same encoding as the RCU PLL table (000/001 = bypass, 010–111 = 3×–8×).
- `pll_lock_i` in 1: PLL lock, asynchronous. Synchronized internally with 2 flops.
- `pll_cfg_o` out 3: code driven to the PLL divider table.
- `pll_bp_o` out 1: force PLL bypass.
- `pll_rst_n_o` out 1: PLL reset, active-low.
- `clk_gate_o` out 1: 1 = gate `sys_clk` at the clock mux output.
- `cur_cfg_o` out 3: code currently in effect.
- `busy_o` out 1: high whenever the FSM is not IDLE.
- `done_o` out 1: one-cycle pulse when a sequence completes successfully.
- `err_o` out 1: sticky lock-timeout flag.
- `lol_o` out 1: sticky loss-of-lock flag, set while IDLE.
- `err_clr_i` in 1: clears `err_o` and `lol_o`.

## Operation
- Reset values: state IDLE, `pll_cfg_o`=000, `cur_cfg_o`=000, `pll_bp_o`=1, `pll_rst_n_o`=0, `clk_gate_o`=0, `cfg_ready_o`=1, `busy_o`=0, `done_o`=0, `err_o`=0, `lol_o`=0. All outputs are registered.
- Handshake: a transfer occurs on `cfg_valid_i && cfg_ready_o`. `cfg_i` is latched into `pend_cfg`. Requests made while busy are not accepted; they stall. A request equal to `cur_cfg_o` still runs the full sequence.
- FSM states: IDLE, GATE, BYPASS, PRST, RELOCK, UNBYP, UNGATE, FAIL. Every timed state loads its counter with 0 on entry and exits when the counter reaches N-1, so each lasts exactly N cycles.
- IDLE → GATE on transfer.
- GATE: `clk_gate_o`=1 for `SETTLE_CYC` cycles, then → BYPASS.
- BYPASS: `pll_bp_o`=1 and `pll_cfg_o`=`pend_cfg` on entry, held for `SETTLE_CYC` cycles.
  - If `pend_cfg` is a bypass code (000/001): → UNGATE. `pll_rst_n_o` is held at 0 and `pll_bp_o` stays 1.
  - Otherwise → PRST.
- PRST: `pll_rst_n_o`=0 for `RST_CYC` cycles, then → RELOCK.
- RELOCK:
  - `pll_rst_n_o`=1 and a timeout counter runs.
  - A stable counter increments on each synchronized lock-high cycle and clears to 0 on any low cycle.
  - stable == `LOCK_STABLE` → UNBYP.
  - Timeout counter == `LOCK_TIMEOUT`-1 without success → FAIL.
  - If both conditions hit in the same cycle, success wins.
- UNBYP: `pll_bp_o`=0 for `SETTLE_CYC` cycles, then → UNGATE.
- UNGATE: `clk_gate_o`=0; `cur_cfg_o`=`pend_cfg`; `done_o` pulses for one cycle; → IDLE. Lasts 1 cycle.
- FAIL (1 cycle), fallback to the safe state:
  - `pll_bp_o`=1, `pll_rst_n_o`=0, `pll_cfg_o`=000, `cur_cfg_o`=000.
  - `clk_gate_o`=0 and `err_o`=1.
  - No `done_o` pulse. → IDLE.
- Loss of lock: in IDLE with `cur_cfg_o` ∉ {000,001}, a synchronized lock low sets `lol_o`. No automatic action is taken.
- `err_clr_i`: clears `err_o` and `lol_o` on the next edge. If a set event occurs in the same cycle as the clear, set wins.
- Asynchronous reset mid-sequence returns all outputs to their reset values immediately. The PLL is left bypassed and held in reset.

## Timing
- Transfer at edge T: the FSM enters GATE at T+1 and `clk_gate_o` rises after T+1; `cfg_ready_o` falls at T+1.
- Bypass-code sequence latency (transfer to `done_o`): 2·`SETTLE_CYC`+1 cycles.
- Lock sequence latency: 3·`SETTLE_CYC` + `RST_CYC` + R + 1 cycles, where R is the RELOCK duration. R ≥ `LOCK_STABLE` + 2 because of the synchronizer.
- Ordering guarantees:
  - `clk_gate_o` is high throughout every cycle in which `pll_bp_o` or `pll_cfg_o` changes.
  - `pll_bp_o` never falls unless accepted lock has been seen.
- `cfg_ready_o` returns to 1 in the cycle after UNGATE or FAIL.

## Test plan
- Reset with default parameters: check every output equals its reset value. Send `cfg_i`=011 with `pll_lock_i` rising 10 cycles after `pll_rst_n_o` rises → `done_o` at 8+8+16+(10+2+4)+8+1 cycles after transfer; `cur_cfg_o`=011, `pll_bp_o`=0, `clk_gate_o`=0.
- `cfg_i`=001 from 011 → `done_o` 17 cycles after transfer; `pll_rst_n_o` is never released; `pll_bp_o`=1.
- `pll_lock_i` held low → FAIL exactly 4096 cycles into RELOCK; `err_o`=1, `cur_cfg_o`=000, `pll_bp_o`=1, no `done_o`. Then pulse `err_clr_i` → `err_o`=0.
- Lock chatter (high 3, low 1, high 4) → stable counter restarts; UNBYP is entered only after the 4-high run.
- `cfg_valid_i` held high during busy → second request accepted only in the cycle after `done_o`. Then drop lock while IDLE at 8× → `lol_o`=1.
- Assert `rst_n_i` during RELOCK → all outputs return to reset values asynchronously; next request completes normally.
